// File: rtl/fp_norm_round.sv
// Post-add normalization and rounding stage for a binary32 adder.
// Three pipeline stages: leading-zero count, shift/round, classify/pack.
// A single global stall freezes every stage while the output is held.

// Logarithmic left barrel shifter: one conditional power-of-two shift per select bit.
module fp_norm_shl #(
  parameter int W  = 25,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  shifted
);
  logic [W-1:0] stg [SW+1];

  assign stg[0] = data;

  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_stage
      // Stage gi shifts by 2**gi when its select bit is set.
      assign stg[gi+1] = sel[gi] ? (stg[gi] << (1 << gi)) : stg[gi];
    end
  endgenerate

  assign shifted = stg[SW];
endmodule

module fp_norm_round #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 25,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [MANT_W-1:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-2:0]   out_data,
  output logic                      out_ovf,
  output logic                      out_unf
);
  localparam int SEL_W  = $clog2(MANT_W);
  localparam int E_W    = EXP_W + 2;
  localparam int FRAC_W = MANT_W - 2;
  localparam int OUT_W  = 1 + EXP_W + FRAC_W;
  // Largest biased exponent is reserved for infinity.
  localparam logic signed [E_W-1:0] E_OVF  = E_W'(2 * BIAS + 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  logic stall;
  logic advance;

  logic                    s1_valid_reg;
  logic                    s1_sign_reg;
  logic [EXP_W-1:0]        s1_exp_reg;
  logic [MANT_W-1:0]       s1_mant_reg;
  logic [SEL_W-1:0]        s1_lzc_reg;
  logic [SEL_W-1:0]        lzc_next;

  logic [MANT_W-1:0]       shl_out;
  logic                    carry;
  logic                    rnd_up;
  logic [MANT_W-1:0]       m_pre;
  logic signed [E_W-1:0]   e_pre;
  logic [MANT_W-2:0]       m_next;
  logic signed [E_W-1:0]   e_next;

  logic                    s2_valid_reg;
  logic                    s2_sign_reg;
  logic signed [E_W-1:0]   s2_e_reg;
  logic [MANT_W-2:0]       s2_m_reg;

  logic [OUT_W-1:0]        pack_data;
  logic                    pack_ovf;
  logic                    pack_unf;

  logic                    out_valid_reg;
  logic [OUT_W-1:0]        out_data_reg;
  logic                    out_ovf_reg;
  logic                    out_unf_reg;

  assign stall    = out_valid_reg & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // Leading zeros of the mantissa below the carry bit; all-zero gives MANT_W-1.
  always_comb begin
    lzc_next = SEL_W'(MANT_W - 1);
    for (int i = 0; i < MANT_W - 1; i++) begin
      if (in_mant[i]) lzc_next = SEL_W'(MANT_W - 2 - i);
    end
  end

  // Stage 1: capture the input word together with its leading-zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_mant_reg  <= '0;
      s1_lzc_reg   <= '0;
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s1_sign_reg  <= in_sign;
      s1_exp_reg   <= in_exp;
      s1_mant_reg  <= in_mant;
      s1_lzc_reg   <= lzc_next;
    end
  end

  fp_norm_shl #(.W(MANT_W), .SW(SEL_W)) u_shl (
    .data    (s1_mant_reg),
    .sel     (s1_lzc_reg),
    .shifted (shl_out)
  );

  // Carry path shifts right and rounds the single dropped bit to even;
  // otherwise the barrel shifter normalizes exactly. A rounding carry into
  // the top bit is folded back by a final one-bit renormalization.
  // A zero mantissa leaves the hidden bit clear, which stage 3 reads as zero.
  always_comb begin
    carry  = s1_mant_reg[MANT_W-1];
    rnd_up = carry & s1_mant_reg[0] & s1_mant_reg[1];
    m_pre  = shl_out;
    e_pre  = {2'b00, s1_exp_reg} - {{(E_W-SEL_W){1'b0}}, s1_lzc_reg};
    if (carry) begin
      m_pre = {1'b0, s1_mant_reg[MANT_W-1:1]} + {{(MANT_W-1){1'b0}}, rnd_up};
      e_pre = {2'b00, s1_exp_reg} + E_W'(1);
    end
    m_next = m_pre[MANT_W-2:0];
    e_next = e_pre;
    if (m_pre[MANT_W-1]) begin
      m_next = m_pre[MANT_W-1:1];
      e_next = e_pre + E_W'(1);
    end
  end

  // Stage 2: hold the normalized mantissa and widened signed exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_sign_reg  <= 1'b0;
      s2_e_reg     <= '0;
      s2_m_reg     <= '0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_e_reg     <= e_next;
      s2_m_reg     <= m_next;
    end
  end

  // Classify into zero / infinity / flush-to-zero / normal and pack.
  always_comb begin
    pack_data = '0;
    pack_ovf  = 1'b0;
    pack_unf  = 1'b0;
    if (!s2_m_reg[MANT_W-2]) begin
      pack_data = '0;
    end else if (s2_e_reg >= E_OVF) begin
      pack_data = {s2_sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      pack_ovf  = 1'b1;
    end else if (s2_e_reg <= E_ZERO) begin
      pack_data = {s2_sign_reg, {(OUT_W-1){1'b0}}};
      pack_unf  = 1'b1;
    end else begin
      pack_data = {s2_sign_reg, s2_e_reg[EXP_W-1:0], s2_m_reg[FRAC_W-1:0]};
    end
  end

  // Stage 3: output register, frozen while downstream is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_unf_reg   <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= s2_valid_reg;
      out_data_reg  <= pack_data;
      out_ovf_reg   <= pack_ovf;
      out_unf_reg   <= pack_unf;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_unf   = out_unf_reg;
endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors, back-pressure,
// mid-stream reset and randomized traffic against an arithmetic model.
module tb_fp_norm_round;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  fp_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] expv;
    int          acc;
  } sb_t;

  sb_t         sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_lat = 0;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;

  // Result as {ovf, unf, data}, from the MSB position of the mantissa.
  function automatic logic [33:0] model(input logic s, input logic [7:0] ex, input logic [24:0] mt);
    int     p;
    int     e;
    longint m;
    if (mt == 25'h0) return 34'h0;
    p = 24;
    while (!mt[p]) p--;
    e = int'(ex) + (p - 23);
    if (p == 24) begin
      m = longint'(mt) >> 1;
      if (mt[0] && m[0]) m = m + 1;
      if (m == (longint'(1) << 24)) begin
        m = longint'(1) << 23;
        e = e + 1;
      end
    end else begin
      m = longint'(mt) << (23 - p);
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b01, s, 31'h0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, sample just after, score any output transfer.
  task automatic cycle(input logic v, input logic s, input logic [7:0] ex, input logic [24:0] mt,
                       input logic [33:0] expv, input logic ordy, output logic acc);
    sb_t ent;
    in_valid  = v;
    in_sign   = s;
    in_exp    = ex;
    in_mant   = mt;
    out_ready = ordy;
    #1;
    acc         = v && in_ready;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("output_expected", {33'h0, sbq.size() != 0}, 34'd1);
      end else begin
        ent = sbq.pop_front();
        chk("result", {out_ovf, out_unf, out_data}, ent.expv);
        last_lat = cyc - ent.acc;
      end
    end
    if (acc) sbq.push_back('{expv, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && sbq.size() != 0; i++)
      cycle(1'b0, 1'b0, 8'd1, 25'h0, 34'h0, 1'b1, a);
    chk("drain_empty", 34'(sbq.size()), 34'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    chk("rst_out_valid", 34'(out_valid), 34'd0);
    chk("rst_out_data",  34'(out_data),  34'd0);
    chk("rst_flags",     34'({out_ovf, out_unf}), 34'd0);
    chk("rst_in_ready",  34'(in_ready),  34'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    logic        sg [6];
    logic [7:0]  ex [6];
    logic [24:0] mt [6];
    logic [31:0] held;
    int          k;
    int          c;
    logic [24:0] r;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd1; in_mant = '0; out_ready = 1'b1;
    @(posedge clk);
    do_reset();

    // Directed vectors from the test plan, first one alone for latency.
    cycle(1, 0, 8'd127, 25'h1000000, {2'b00, 32'h40000000}, 1, a);
    for (int i = 0; i < 6 && sbq.size() != 0; i++) cycle(0, 0, 8'd1, 25'h0, 34'h0, 1, a);
    chk("latency", 34'(last_lat), 34'd3);
    chk("latency_drained", 34'(sbq.size()), 34'd0);

    cycle(1, 0, 8'd127, 25'h0000001, {2'b00, 32'h34000000}, 1, a);
    cycle(1, 0, 8'd127, 25'h0800000, {2'b00, 32'h3F800000}, 1, a);
    cycle(1, 0, 8'd127, 25'h1FFFFFF, {2'b00, 32'h40800000}, 1, a);
    cycle(1, 0, 8'd127, 25'h1000001, {2'b00, 32'h40000000}, 1, a);
    cycle(1, 0, 8'd254, 25'h1000000, {2'b10, 32'h7F800000}, 1, a);
    cycle(1, 1, 8'd10,  25'h0000001, {2'b01, 32'h80000000}, 1, a);
    cycle(1, 0, 8'd127, 25'h0000000, {2'b00, 32'h00000000}, 1, a);
    cycle(1, 1, 8'd200, 25'h0ABCDEF, {2'b00, 32'hE42BCDEF}, 1, a);
    cycle(1, 0, 8'd23,  25'h0000001, {2'b01, 32'h00000000}, 1, a);
    cycle(1, 0, 8'd24,  25'h0000001, {2'b00, 32'h00800000}, 1, a);
    cycle(1, 1, 8'd253, 25'h1FFFFFF, {2'b10, 32'hFF800000}, 1, a);
    drain();

    // Back-pressure: six words streamed, downstream stalled on calls 4..8.
    for (int i = 0; i < 6; i++) begin
      sg[i] = i[0];
      ex[i] = 8'(100 + 7 * i);
      mt[i] = 25'h0400000 + 25'(i * 25'h011111) + ((i == 2) ? 25'h1000000 : 25'h0);
    end
    k = 0;
    c = 0;
    held = '0;
    while (k < 6 && c < 40) begin
      c++;
      cycle(1, sg[k], ex[k], mt[k], model(sg[k], ex[k], mt[k]), !(c >= 4 && c <= 8), a);
      if (a) k++;
      if (c >= 4 && c <= 8) begin
        chk("stall_in_ready", 34'(s_in_ready), 34'd0);
        chk("stall_out_valid", 34'(s_out_valid), 34'd1);
        if (c == 4) held = s_out_data;
        else chk("stall_hold", 34'(s_out_data), 34'(held));
      end
    end
    chk("stream_accepted", 34'(k), 34'd6);
    drain();

    // Reset with three words in flight: none may surface afterwards.
    cycle(1, 0, 8'd127, 25'h0800000, 34'h0, 1, a);
    cycle(1, 0, 8'd128, 25'h0800000, 34'h0, 1, a);
    cycle(1, 0, 8'd129, 25'h0800000, 34'h0, 1, a);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 8'd1, 25'h0, 34'h0, 1, a);
      chk("post_rst_idle", 34'(s_out_valid), 34'd0);
    end

    // Randomized traffic with random valid and ready.
    for (int i = 0; i < 400; i++) begin
      logic       s;
      logic [7:0] e;
      s = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 8'd254 : 8'd1)
                                      : 8'($urandom_range(1, 254));
      case ($urandom_range(0, 3))
        0: r = 25'($urandom);
        1: r = 25'($urandom) >> $urandom_range(0, 24);
        2: r = 25'h1000000 | 25'($urandom);
        default: r = ($urandom_range(0, 3) == 0) ? 25'h0 : (25'($urandom) >> 20);
      endcase
      cycle($urandom_range(0, 3) != 0, s, e, r, model(s, e, r), $urandom_range(0, 3) != 0, a);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
